inst_cache: RTL and testbench

//  Read-only direct-mapped instruction cache between the instruction fetcher (IF) and the

---
 rtl/inst_cache_pkg.sv | 13 +
 rtl/icache_array.sv | 55 +++++
 rtl/inst_cache.sv | 188 ++++++++++++++++++
 tb/tb_inst_cache.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int ICACHE_IDX_BITS = 5;
  localparam int ICACHE_OFF_BITS = 2;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_RESP   = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one async read port,
// one word write port, and a tag+valid write that installs a completed line.
module icache_array #(
  parameter int IDX_BITS = 5,
  parameter int OFF_BITS = 2,
  parameter int TAG_BITS = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  input  logic [OFF_BITS-1:0] i_rd_off,
  output logic                o_rd_valid,
  output logic [TAG_BITS-1:0] o_rd_tag,
  output logic [31:0]         o_rd_data,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [OFF_BITS-1:0] i_wr_off,
  input  logic [31:0]         i_wr_data,
  input  logic                i_line_we,
  input  logic [TAG_BITS-1:0] i_line_tag
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int WORDS = 1 << OFF_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES][WORDS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_line_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether a line can hit, and a reset loop would block RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
    if (i_line_we) begin
      r_tag[i_wr_idx] <= i_line_tag;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/inst_cache.sv
// Read-only direct-mapped instruction cache between the fetch stage and the
// memory controller; misses refill a whole line one word per controller fetch.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS,
  parameter int OFF_BITS = ICACHE_OFF_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_fetch_en,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int TAG_BITS  = 32 - 2 - OFF_BITS - IDX_BITS;
  localparam int LINE_BITS = 30 - OFF_BITS;

  ic_state_e             r_state,   w_state_nxt;
  logic [LINE_BITS-1:0]  r_line,    w_line_nxt;
  logic [OFF_BITS-1:0]   r_req_off, w_req_off_nxt;
  logic [OFF_BITS-1:0]   r_word_cnt, w_cnt_nxt;
  logic                  r_cancel,  w_cancel_nxt;
  logic                  r_if_valid, w_if_valid_nxt;
  logic [31:0]           r_if_inst, w_if_inst_nxt;
  logic                  r_fetch_en, w_fetch_en_nxt;
  logic [31:0]           r_mem_addr, w_mem_addr_nxt;

  logic [IDX_BITS-1:0]   w_pc_idx;
  logic [OFF_BITS-1:0]   w_pc_off;
  logic [TAG_BITS-1:0]   w_pc_tag;
  logic [IDX_BITS-1:0]   w_line_idx;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic [IDX_BITS-1:0]   w_rd_idx;
  logic [OFF_BITS-1:0]   w_rd_off;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [31:0]           w_rd_data;
  logic                  w_hit;
  logic                  w_last;
  logic [OFF_BITS-1:0]   w_cnt_inc;
  logic                  w_data_we;
  logic                  w_line_we;
  logic                  w_unused;

  assign w_pc_idx   = if_pc[2+OFF_BITS +: IDX_BITS];
  assign w_pc_off   = if_pc[2 +: OFF_BITS];
  assign w_pc_tag   = if_pc[31 -: TAG_BITS];
  assign w_line_idx = r_line[IDX_BITS-1:0];
  assign w_line_tag = r_line[LINE_BITS-1 -: TAG_BITS];
  assign w_unused   = &{1'b0, if_pc[1:0]};

  // During refill the read port serves the requested word for the final response.
  assign w_rd_idx  = (r_state == IC_REFILL) ? w_line_idx : w_pc_idx;
  assign w_rd_off  = (r_state == IC_REFILL) ? r_req_off  : w_pc_off;
  assign w_hit     = w_rd_valid && (w_rd_tag == w_pc_tag);
  assign w_last    = (r_word_cnt == {OFF_BITS{1'b1}});
  assign w_cnt_inc = r_word_cnt + 1'b1;

  icache_array #(
    .IDX_BITS (IDX_BITS),
    .OFF_BITS (OFF_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_rd_idx),
    .i_rd_off   (w_rd_off),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_data_we && rdy),
    .i_wr_idx   (w_line_idx),
    .i_wr_off   (r_word_cnt),
    .i_wr_data  (mem_data),
    .i_line_we  (w_line_we && rdy),
    .i_line_tag (w_line_tag)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_line_nxt     = r_line;
    w_req_off_nxt  = r_req_off;
    w_cnt_nxt      = r_word_cnt;
    w_cancel_nxt   = r_cancel;
    w_if_valid_nxt = 1'b0;
    w_if_inst_nxt  = r_if_inst;
    w_fetch_en_nxt = r_fetch_en;
    w_mem_addr_nxt = r_mem_addr;
    w_data_we      = 1'b0;
    w_line_we      = 1'b0;

    case (r_state)
      IC_IDLE: begin
        w_cancel_nxt = 1'b0;
        if (if_req && !clear) begin
          if (w_hit) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = w_rd_data;
            w_state_nxt    = IC_RESP;
          end else begin
            w_line_nxt     = if_pc[31:2+OFF_BITS];
            w_req_off_nxt  = w_pc_off;
            w_cnt_nxt      = '0;
            w_fetch_en_nxt = 1'b1;
            w_mem_addr_nxt = {if_pc[31:2+OFF_BITS], {(OFF_BITS+2){1'b0}}};
            w_state_nxt    = IC_REFILL;
          end
        end
      end

      IC_REFILL: begin
        if (clear) begin
          w_cancel_nxt = 1'b1;
        end
        if (r_fetch_en && mem_valid) begin
          w_data_we      = 1'b1;
          w_fetch_en_nxt = 1'b0;
          if (w_last) begin
            w_line_we    = 1'b1;
            w_cancel_nxt = 1'b0;
            if (r_cancel || clear) begin
              w_state_nxt = IC_IDLE;
            end else begin
              // The requested word may be the one arriving right now.
              w_if_valid_nxt = 1'b1;
              w_if_inst_nxt  = (r_req_off == r_word_cnt) ? mem_data : w_rd_data;
              w_state_nxt    = IC_RESP;
            end
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_mem_addr_nxt = {r_line, w_cnt_inc, 2'b00};
          end
        end else if (!r_fetch_en) begin
          // One idle cycle after each word lets the controller pass through STALL.
          w_fetch_en_nxt = 1'b1;
        end
      end

      IC_RESP: begin
        w_state_nxt = IC_IDLE;
      end

      default: begin
        w_state_nxt = IC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IC_IDLE;
      r_line     <= '0;
      r_req_off  <= '0;
      r_word_cnt <= '0;
      r_cancel   <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      r_fetch_en <= 1'b0;
      r_mem_addr <= '0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_line     <= w_line_nxt;
      r_req_off  <= w_req_off_nxt;
      r_word_cnt <= w_cnt_nxt;
      r_cancel   <= w_cancel_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_inst  <= w_if_inst_nxt;
      r_fetch_en <= w_fetch_en_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  assign if_valid     = r_if_valid;
  assign if_inst      = r_if_inst;
  assign mem_fetch_en = r_fetch_en;
  assign mem_addr     = r_mem_addr;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a small memory-controller responder returns
// {~addr[15:0], addr[15:0]} for each fetched word; expectations are literals.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        mem_fetch_en;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int          checks;
  int          errors;
  int          cyc;
  int          valid_cyc;
  int          resp_cyc;
  int          drop_err;
  bit          saw_fetch;
  logic [31:0] fetch_q[$];

  localparam int LAT = 2;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clear        (clear),
    .if_req       (if_req),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .mem_fetch_en (mem_fetch_en),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory controller model: fixed latency, records each fetched address and
  // checks the one-cycle fetch_en drop after every delivered word.
  initial begin
    int          wait_cnt;
    int          stage;
    bit          last_word;
    logic [31:0] exp_next;
    wait_cnt  = 0;
    stage     = 0;
    last_word = 1'b0;
    exp_next  = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    valid_cyc = -10;
    drop_err  = 0;
    forever begin
      @(negedge clk);
      #1;
      mem_valid = 1'b0;
      if (rst) begin
        wait_cnt = 0;
        stage    = 0;
      end else if (rdy) begin
        if (stage == 1) begin
          if (mem_fetch_en) drop_err++;
          stage = last_word ? 0 : 2;
        end else if (stage == 2) begin
          if (!mem_fetch_en || mem_addr !== exp_next) drop_err++;
          stage = 0;
        end
        if (stage == 0 && mem_fetch_en) begin
          wait_cnt++;
          if (wait_cnt >= LAT) begin
            mem_valid = 1'b1;
            mem_data  = {~mem_addr[15:0], mem_addr[15:0]};
            fetch_q.push_back(mem_addr);
            last_word = (mem_addr[3:2] == 2'b11);
            exp_next  = mem_addr + 32'd4;
            stage     = 1;
            wait_cnt  = 0;
            valid_cyc = cyc;
          end
        end
      end
    end
  end

  // Issues one fetch request and waits (bounded) for its response.
  task automatic do_req(input logic [31:0] pc, output bit got, output logic [31:0] inst,
                        output int lat);
    got       = 1'b0;
    inst      = '0;
    lat       = 0;
    saw_fetch = 1'b0;
    if_pc     = pc;
    if_req    = 1'b1;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_fetch_en) saw_fetch = 1'b1;
      if (if_valid) begin
        got  = 1'b1;
        inst = if_inst;
      end
    end
    resp_cyc = cyc;
    if_req   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    rdy    = 1'b1;
    clear  = 1'b0;
    if_req = 1'b0;
    if_pc  = '0;
    repeat (3) @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h want 0", if_inst); end
    checks++; if (mem_fetch_en !== 1'b0) begin errors++; $display("FAIL reset_fetch_en got %b want 0", mem_fetch_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss_refill();
    bit got; logic [31:0] inst; int lat; int n0; int d0;
    n0 = fetch_q.size();
    d0 = drop_err;
    do_req(32'h0, got, inst, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL miss0_response got none want if_valid"); end
    checks++; if (inst !== 32'hFFFF_0000) begin errors++; $display("FAIL miss0_inst got %h want ffff0000", inst); end
    checks++; if (fetch_q.size() - n0 != 4) begin errors++; $display("FAIL miss0_fetch_count got %0d want 4", fetch_q.size() - n0); end
    if (fetch_q.size() - n0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fetch_q[n0+i] !== 32'(4 * i)) begin
          errors++; $display("FAIL miss0_addr%0d got %h want %h", i, fetch_q[n0+i], 32'(4 * i));
        end
      end
    end
    checks++; if (resp_cyc != valid_cyc + 1) begin errors++; $display("FAIL miss0_resp_timing got cycle %0d want %0d", resp_cyc, valid_cyc + 1); end
    checks++; if (drop_err != d0) begin errors++; $display("FAIL miss0_fetch_en_drop got %0d violations want 0", drop_err - d0); end
  endtask

  task automatic test_hit();
    bit got; logic [31:0] inst; int lat; int n0;
    n0 = fetch_q.size();
    do_req(32'h8, got, inst, lat);
    checks++; if (lat != 1 || !got) begin errors++; $display("FAIL hit8_latency got %0d want 1", lat); end
    checks++; if (inst !== 32'hFFF7_0008) begin errors++; $display("FAIL hit8_inst got %h want fff70008", inst); end
    checks++; if (saw_fetch || fetch_q.size() != n0) begin errors++; $display("FAIL hit8_no_fetch got fetch_en %b words %0d want 0 0", saw_fetch, fetch_q.size() - n0); end
  endtask

  task automatic test_evict();
    bit got; logic [31:0] inst; int lat; int n0;
    n0 = fetch_q.size();
    do_req(32'h200, got, inst, lat);
    checks++; if (inst !== 32'hFDFF_0200) begin errors++; $display("FAIL evict_inst200 got %h want fdff0200", inst); end
    checks++; if (fetch_q.size() - n0 != 4) begin errors++; $display("FAIL evict_fetch_count got %0d want 4", fetch_q.size() - n0); end
    if (fetch_q.size() - n0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fetch_q[n0+i] !== 32'h200 + 32'(4 * i)) begin
          errors++; $display("FAIL evict_addr%0d got %h want %h", i, fetch_q[n0+i], 32'h200 + 32'(4 * i));
        end
      end
    end
    n0 = fetch_q.size();
    do_req(32'h0, got, inst, lat);
    checks++; if (fetch_q.size() - n0 != 4 || lat <= 1) begin errors++; $display("FAIL evict_remiss0 got %0d words latency %0d want 4 words", fetch_q.size() - n0, lat); end
    checks++; if (inst !== 32'hFFFF_0000) begin errors++; $display("FAIL evict_inst0 got %h want ffff0000", inst); end
  endtask

  task automatic test_bypass();
    bit got; logic [31:0] inst; int lat; int n0;
    n0 = fetch_q.size();
    do_req(32'h10C, got, inst, lat);
    checks++; if (inst !== 32'hFEF3_010C) begin errors++; $display("FAIL bypass_inst got %h want fef3010c", inst); end
    checks++; if (resp_cyc != valid_cyc + 1) begin errors++; $display("FAIL bypass_timing got cycle %0d want %0d", resp_cyc, valid_cyc + 1); end
    checks++; if (fetch_q.size() - n0 != 4 || fetch_q[n0] !== 32'h100) begin errors++; $display("FAIL bypass_fetch got %0d words want 4 from 00000100", fetch_q.size() - n0); end
  endtask

  task automatic test_cancel();
    bit got; logic [31:0] inst; int lat; int n0; int guard; bit saw_valid;
    n0        = fetch_q.size();
    saw_valid = 1'b0;
    guard     = 0;
    if_pc     = 32'h40;
    if_req    = 1'b1;
    while (fetch_q.size() < n0 + 1 && guard < 100) begin
      @(negedge clk); guard++;
      if (if_valid) saw_valid = 1'b1;
    end
    clear  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    if (if_valid) saw_valid = 1'b1;
    guard = 0;
    while (fetch_q.size() < n0 + 4 && guard < 100) begin
      @(negedge clk); guard++;
      if (if_valid) saw_valid = 1'b1;
    end
    repeat (4) begin
      @(negedge clk);
      if (if_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL cancel_no_valid got if_valid 1 want 0"); end
    checks++; if (fetch_q.size() - n0 != 4) begin errors++; $display("FAIL cancel_fetch_count got %0d want 4", fetch_q.size() - n0); end
    if (fetch_q.size() - n0 >= 4) begin
      checks++; if (fetch_q[n0+3] !== 32'h4C) begin errors++; $display("FAIL cancel_last_addr got %h want 0000004c", fetch_q[n0+3]); end
    end
    checks++; if (mem_fetch_en !== 1'b0) begin errors++; $display("FAIL cancel_fetch_idle got %b want 0", mem_fetch_en); end

    // A flush in IDLE suppresses a hit; the held request then hits normally.
    n0     = fetch_q.size();
    if_pc  = 32'h44;
    if_req = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL clear_idle_suppress got %b want 0", if_valid); end
    clear = 1'b0;
    do_req(32'h44, got, inst, lat);
    checks++; if (lat != 1 || !got) begin errors++; $display("FAIL hit44_latency got %0d want 1", lat); end
    checks++; if (inst !== 32'hFFBB_0044) begin errors++; $display("FAIL hit44_inst got %h want ffbb0044", inst); end
    checks++; if (fetch_q.size() != n0) begin errors++; $display("FAIL hit44_no_fetch got %0d words want 0", fetch_q.size() - n0); end
  endtask

  task automatic test_rdy_freeze();
    bit got; logic [31:0] inst; int n0; int guard;
    n0     = fetch_q.size();
    guard  = 0;
    got    = 1'b0;
    inst   = '0;
    if_pc  = 32'h80;
    if_req = 1'b1;
    while (!(mem_fetch_en && mem_addr == 32'h84) && guard < 100) begin
      @(negedge clk); guard++;
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL freeze_reach_word1 got timeout want fetch of 00000084"); end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mem_addr !== 32'h84 || mem_fetch_en !== 1'b1 || if_valid !== 1'b0) begin
        errors++; $display("FAIL freeze_hold%0d got addr %h en %b valid %b want 00000084 1 0", i, mem_addr, mem_fetch_en, if_valid);
      end
    end
    checks++; if (fetch_q.size() - n0 != 1) begin errors++; $display("FAIL freeze_no_words got %0d want 1", fetch_q.size() - n0); end
    rdy   = 1'b1;
    guard = 0;
    while (!got && guard < 200) begin
      @(negedge clk); guard++;
      if (if_valid) begin got = 1'b1; inst = if_inst; end
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (inst !== 32'hFF7F_0080) begin errors++; $display("FAIL freeze_inst got %h want ff7f0080", inst); end
    checks++; if (fetch_q.size() - n0 != 4 || fetch_q[fetch_q.size()-1] !== 32'h8C) begin errors++; $display("FAIL freeze_fetch got %0d words want 4 ending 0000008c", fetch_q.size() - n0); end
  endtask

  task automatic test_rst_mid_refill();
    bit got; logic [31:0] inst; int lat; int n0; int guard;
    guard  = 0;
    if_pc  = 32'hC0;
    if_req = 1'b1;
    while (!(mem_fetch_en && mem_addr == 32'hC4) && guard < 100) begin
      @(negedge clk); guard++;
    end
    rst    = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_fetch_en !== 1'b0) begin errors++; $display("FAIL rst_mid_fetch_en got %b want 0", mem_fetch_en); end
    checks++; if (if_valid !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got valid %b addr %h want 0 0", if_valid, mem_addr); end
    rst = 1'b0;
    @(negedge clk);
    n0 = fetch_q.size();
    do_req(32'hC0, got, inst, lat);
    checks++; if (fetch_q.size() - n0 != 4 || lat <= 1) begin errors++; $display("FAIL rst_remiss_c0 got %0d words want 4", fetch_q.size() - n0); end
    checks++; if (inst !== 32'hFF3F_00C0) begin errors++; $display("FAIL rst_inst_c0 got %h want ff3f00c0", inst); end
    n0 = fetch_q.size();
    do_req(32'h8, got, inst, lat);
    checks++; if (fetch_q.size() - n0 != 4 || inst !== 32'hFFF7_0008) begin errors++; $display("FAIL rst_remiss_8 got %0d words inst %h want 4 fff70008", fetch_q.size() - n0, inst); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_miss_refill();
    test_hit();
    test_evict();
    test_bypass();
    test_cancel();
    test_rdy_freeze();
    test_rst_mid_refill();
    checks++; if (drop_err != 0) begin errors++; $display("FAIL fetch_en_gap got %0d violations want 0", drop_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
